vdot_sched: RTL

- Two-requester scheduler for the pipelined 16-lane half-precision dot-product unit.
- Accepts dot-product jobs (two 256-bit operand vectors) from two issuers and arbitrates them round-robin, issuing at most one job per clock into the fully pipelined datapath.
- Tracks each job's owner through a tag pipeline matched to datapath latency, and returns the 16-bit result and overflow flag to the correct requester.
- Sits between the vector issue logic and the dot-product datapath.

---
 rtl/vdot_sched.sv | 144 ++++++++++++++
 1 files changed

// File: rtl/vdot_sched.sv
// Round-robin two-requester scheduler for the pipelined fp16 dot-product unit.
// Define VDOT_SCHED_STATS_EN to add the job_cnt/ovf_cnt statistics outputs.
module vdot_sched #(
  parameter int LAT     = 5,
  parameter int MAX_OUT = 4
) (
  input  logic         Clk,
  input  logic         Rst_n,
  input  logic         req0,
  input  logic [255:0] a0,
  input  logic [255:0] b0,
  output logic         gnt0,
  input  logic         req1,
  input  logic [255:0] a1,
  input  logic [255:0] b1,
  output logic         gnt1,
  output logic [255:0] dp_A,
  output logic [255:0] dp_B,
  input  logic [15:0]  dp_out,
  input  logic         dp_V,
  output logic         rsp_valid0,
  output logic         rsp_valid1,
  output logic [15:0]  rsp_data,
  output logic         rsp_V,
  output logic         busy
`ifdef VDOT_SCHED_STATS_EN
  ,
  output logic [31:0]  job_cnt,
  output logic [15:0]  ovf_cnt
`endif
);

  typedef enum logic {PRI0, PRI1} prio_e;

  typedef struct packed {
    logic v;
    logic id;
  } tag_t;

  prio_e        ptr, ptr_nx;
  tag_t [LAT:0] tags;
  logic [3:0]   cnt0, cnt1;
  logic         el0, el1;
  logic         acc, ret0, ret1;

  // Reset gates eligibility so no grant is shown while held in reset.
  always_comb begin
    el0    = Rst_n & req0 & (cnt0 < 4'(MAX_OUT));
    el1    = Rst_n & req1 & (cnt1 < 4'(MAX_OUT));
    gnt0   = 1'b0;
    gnt1   = 1'b0;
    ptr_nx = ptr;
    unique case (1'b1)
      (el0 & ~el1): gnt0 = 1'b1;
      (el1 & ~el0): gnt1 = 1'b1;
      (el0 & el1): begin
        gnt0 = (ptr == PRI0);
        gnt1 = (ptr == PRI1);
      end
      default: ;
    endcase
    if (gnt0)
      ptr_nx = PRI1;
    else if (gnt1)
      ptr_nx = PRI0;
  end

  assign acc  = gnt0 | gnt1;
  assign ret0 = tags[LAT].v & ~tags[LAT].id;
  assign ret1 = tags[LAT].v & tags[LAT].id;

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n)
      ptr <= PRI0;
    else
      ptr <= ptr_nx;
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      dp_A <= '0;
      dp_B <= '0;
      tags <= '0;
    end else begin
      dp_A <= gnt0 ? a0 : (gnt1 ? a1 : '0);
      dp_B <= gnt0 ? b0 : (gnt1 ? b1 : '0);
      tags[LAT:1] <= tags[LAT-1:0];
      tags[0]     <= '{v: acc, id: gnt1};
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      cnt0 <= '0;
      cnt1 <= '0;
    end else begin
      if (gnt0 && !ret0)
        cnt0 <= cnt0 + 4'd1;
      else if (!gnt0 && ret0)
        cnt0 <= cnt0 - 4'd1;
      if (gnt1 && !ret1)
        cnt1 <= cnt1 + 4'd1;
      else if (!gnt1 && ret1)
        cnt1 <= cnt1 - 4'd1;
    end
  end

  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      rsp_valid0 <= 1'b0;
      rsp_valid1 <= 1'b0;
      rsp_data   <= '0;
      rsp_V      <= 1'b0;
    end else begin
      rsp_valid0 <= ret0;
      rsp_valid1 <= ret1;
      if (tags[LAT].v) begin
        rsp_data <= dp_out;
        rsp_V    <= dp_V;
      end
    end
  end

  always_comb begin
    busy = rsp_valid0 | rsp_valid1;
    for (int i = 0; i <= LAT; i++)
      busy = busy | tags[i].v;
  end

`ifdef VDOT_SCHED_STATS_EN
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      job_cnt <= '0;
      ovf_cnt <= '0;
    end else begin
      if (acc)
        job_cnt <= job_cnt + 32'd1;
      if (tags[LAT].v && dp_V && ovf_cnt != 16'hFFFF)
        ovf_cnt <= ovf_cnt + 16'd1;
    end
  end
`endif

endmodule
